// File: rtl/chacha_seed_sched.sv
// Seed scheduler: warms up after reset, then samples the free-running LFSR
// every STRIDE cycles (rejecting all-zero words) and streams the accepted
// words to one of two round-robin arbitrated consumers (key / nonce loader).
module chacha_seed_sched #(
  parameter int unsigned N           = 32,
  parameter int unsigned WARMUP      = 1024,
  parameter int unsigned STRIDE      = 4,
  parameter int unsigned KEY_WORDS   = 8,
  parameter int unsigned NONCE_WORDS = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] rng_word,
  input  logic [1:0]   req,
  output logic [1:0]   grant,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         warm_done,
  output logic         zero_rej
);

  localparam int unsigned WARM_W    = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int unsigned STRIDE_W  = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int unsigned MAX_WORDS = (KEY_WORDS > NONCE_WORDS) ? KEY_WORDS : NONCE_WORDS;
  localparam int unsigned WCNT_W    = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  localparam logic [WARM_W-1:0]   WARM_LAST   = WARM_W'(WARMUP - 1);
  localparam logic [STRIDE_W-1:0] STRIDE_LAST = STRIDE_W'(STRIDE - 1);
  localparam logic [WCNT_W-1:0]   KEY_LAST    = WCNT_W'(KEY_WORDS - 1);
  localparam logic [WCNT_W-1:0]   NONCE_LAST  = WCNT_W'(NONCE_WORDS - 1);

  typedef enum logic [1:0] {
    ST_WARM  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OFFER = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [WARM_W-1:0]   warm_cnt, warm_cnt_d;
  logic [STRIDE_W-1:0] stride_cnt, stride_cnt_d;
  logic [WCNT_W-1:0]   word_cnt, word_cnt_d;
  logic                prio, prio_d;
  logic [1:0]          grant_d;
  logic [N-1:0]        out_data_d;
  logic                out_valid_d, out_last_d, warm_done_d, zero_rej_d;

  logic [1:0]          win_c;
  logic                warm_hit_c, stride_hit_c, rng_zero_c, accept_c;
  logic [WCNT_W-1:0]   last_idx_c;

  // Shared decode: arbitration winner, counter terminal hits, handshake
  always_comb begin
    warm_hit_c   = (warm_cnt == WARM_LAST);
    stride_hit_c = (stride_cnt == STRIDE_LAST);
    rng_zero_c   = (rng_word == '0);
    accept_c     = out_valid & out_ready;
    last_idx_c   = grant[0] ? KEY_LAST : NONCE_LAST;
    unique case (req)
      2'b01:   win_c = 2'b01;
      2'b10:   win_c = 2'b10;
      2'b11:   win_c = prio ? 2'b10 : 2'b01;
      default: win_c = 2'b00;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_WARM;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_WARM:  if (warm_hit_c) state_d = ST_IDLE;
      ST_IDLE:  if (req != 2'b00) state_d = ST_WAIT;
      ST_WAIT:  if (stride_hit_c && !rng_zero_c) state_d = ST_OFFER;
      ST_OFFER: if (accept_c) state_d = out_last ? ST_IDLE : ST_WAIT;
      default:  state_d = ST_WARM;
    endcase
  end

  // Next values of counters, pointer and registered outputs
  always_comb begin
    warm_cnt_d   = warm_cnt;
    stride_cnt_d = stride_cnt;
    word_cnt_d   = word_cnt;
    prio_d       = prio;
    grant_d      = grant;
    out_data_d   = out_data;
    out_valid_d  = out_valid;
    out_last_d   = out_last;
    warm_done_d  = warm_done;
    zero_rej_d   = 1'b0;
    unique case (state_q)
      ST_WARM: begin
        if (warm_hit_c) warm_done_d = 1'b1;
        else            warm_cnt_d  = warm_cnt + WARM_W'(1);
      end
      ST_IDLE: begin
        if (req != 2'b00) begin
          grant_d      = win_c;
          word_cnt_d   = '0;
          stride_cnt_d = '0;
        end
      end
      ST_WAIT: begin
        if (stride_hit_c) begin
          stride_cnt_d = '0;
          if (rng_zero_c) begin
            zero_rej_d = 1'b1;
          end else begin
            out_data_d  = rng_word;
            out_valid_d = 1'b1;
            out_last_d  = (word_cnt == last_idx_c);
          end
        end else begin
          stride_cnt_d = stride_cnt + STRIDE_W'(1);
        end
      end
      ST_OFFER: begin
        if (accept_c) begin
          word_cnt_d   = word_cnt + WCNT_W'(1);
          out_valid_d  = 1'b0;
          stride_cnt_d = '0;
          if (out_last) begin
            out_last_d = 1'b0;
            grant_d    = 2'b00;
            // Hand priority to whichever requester was not just served
            prio_d     = grant[0];
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      warm_cnt   <= '0;
      stride_cnt <= '0;
      word_cnt   <= '0;
      prio       <= 1'b0;
      grant      <= 2'b00;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      warm_done  <= 1'b0;
      zero_rej   <= 1'b0;
    end else begin
      warm_cnt   <= warm_cnt_d;
      stride_cnt <= stride_cnt_d;
      word_cnt   <= word_cnt_d;
      prio       <= prio_d;
      grant      <= grant_d;
      out_data   <= out_data_d;
      out_valid  <= out_valid_d;
      out_last   <= out_last_d;
      warm_done  <= warm_done_d;
      zero_rej   <= zero_rej_d;
    end
  end

endmodule
